// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR; shifts left with XOR feedback into bit 0.
// The serial output q is the MSB of the state register.
module lfsr #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter logic [WIDTH-1:0] SEED  = 'h01
) (
    input  logic clk,
    input  logic reset,
    output logic q
);

    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] nxt;
    logic             fb;

    always_comb begin
        fb  = ^(r1 & TAPS);
        nxt = {r1[WIDTH-2:0], fb};
        // All-zero is a lock-up state for XOR feedback; force recovery to 1.
        if (r1 == '0)
            nxt = WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset)
            r1 <= SEED;
        else
            r1 <= nxt;
    end

    assign q = r1[WIDTH-1];

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: arithmetic reference model checked every cycle, plus
// directed vectors for reset, the opening sequence, period, reset and lock-up recovery.
module tb_lfsr;

    localparam int unsigned TAPS_I = 'hB8;
    localparam int unsigned SEED_I = 'h01;

    logic clk;
    logic reset;
    logic q;

    int n_cmp;
    int n_bad;

    logic [7:0] m;
    logic       m_valid;
    logic       run_done;

    lfsr #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual != expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Next state from the polynomial rule: double mod 256, add parity of tapped bits.
    function automatic int model_step(input int s);
        int ones;
        if (s == 0)
            return 1;
        ones = 0;
        for (int i = 0; i < 8; i++)
            if (((s >> i) & 1) == 1 && ((TAPS_I >> i) & 1) == 1)
                ones++;
        return ((s * 2) % 256) + (ones % 2);
    endfunction

    initial begin
        m       = '0;
        m_valid = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m       = 8'(SEED_I);
            m_valid = 1'b1;
        end else if (m_valid) begin
            m = 8'(model_step(int'(m)));
        end
    end

    initial begin
        run_done = 1'b0;
        forever begin
            @(negedge clk);
            if (run_done)
                break;
            if (m_valid) begin
                check("model_r1", int'(dut.r1), int'(m));
                check("model_q", int'(q), int'(m[7]));
            end
        end
    end

    initial begin
        int exp_seq[8];
        int seen[256];
        int early;
        int zero_hits;
        int singles;
        int r;

        exp_seq = '{'h02, 'h04, 'h08, 'h11, 'h23, 'h47, 'h8E, 'h1C};
        n_cmp = 0;
        n_bad = 0;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_r1", int'(dut.r1), 'h01);
        check("reset_q", int'(q), 0);

        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("seq_r1", int'(dut.r1), exp_seq[i]);
            check("seq_q", int'(q), (exp_seq[i] == 'h8E) ? 1 : 0);
        end

        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 256; i++)
            seen[i] = 0;
        early = 0;
        zero_hits = 0;
        for (int step = 1; step <= 255; step++) begin
            @(posedge clk);
            #1;
            r = int'(dut.r1);
            if (r == 0)
                zero_hits++;
            if (r == 1 && step < 255)
                early++;
            seen[r]++;
            if (int'(q) != ((r >> 7) & 1))
                check("q_is_msb", int'(q), (r >> 7) & 1);
        end
        check("period_back_to_seed", int'(dut.r1), 'h01);
        check("period_no_early_seed", early, 0);
        check("period_no_zero", zero_hits, 0);
        singles = 0;
        for (int v = 1; v < 256; v++)
            if (seen[v] == 1)
                singles++;
        check("period_distinct", singles, 255);

        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_r1", int'(dut.r1), 'h01);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("restart_r1_0", int'(dut.r1), 'h02);
        @(posedge clk);
        #1;
        check("restart_r1_1", int'(dut.r1), 'h04);

        @(negedge clk);
        #1;
        force dut.r1 = 8'h00;
        m = 8'h00;
        #1;
        release dut.r1;
        @(posedge clk);
        #1;
        check("lockup_recover", int'(dut.r1), 'h01);
        @(posedge clk);
        #1;
        check("lockup_resume_0", int'(dut.r1), 'h02);
        @(posedge clk);
        #1;
        check("lockup_resume_1", int'(dut.r1), 'h04);

        repeat (3) @(posedge clk);
        run_done = 1'b1;
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
